tdm_demux_1bit: RTL
===================

# tdm_demux_1bit

Time-division demultiplexer. It receives a 1-bit serial stream in which each valid beat carries one lane's bit, starting at lane 0. It reassembles the beats into an N-bit parallel word and publishes the word atomically once the frame is complete. It sits at the receiving end of a link whose transmit side scans an N:1 multiplexer with a slot counter, and it restores the N parallel lines.

## Interface
- `N`, default 4: number of lanes per frame; legal range N ≥ 2.
- `clk` input 1: sole clock; all state updates on its rising edge.
- `reset` input 1: synchronous, active-high reset.
- `din` input 1: serial data bit for the current slot.
- `din_valid` input 1: `din` is sampled on this edge only when high.
- `frame_start` input 1: qualifies the current valid beat as slot 0; ignored when `din_valid` is low.
- `w` output N: last completed frame; `w[k]` holds the bit received in slot k.
- `slot` output $clog2(N): index of the next slot expected.
- `frame_valid` output 1: one-cycle pulse; `w` has just been updated.
- `sync_err` output 1: one-cycle pulse; a partial frame was abandoned.

## Operation
- States:
  - IDLE: waiting for a frame.
  - RUN: frame in progress.
- Internal shadow register `sh[N-1:0]` accumulates bits. `w` changes only on frame completion.
- Beat definitions:
  - A beat is a rising edge with `din_valid`=1.
  - A start beat is a beat that also has `frame_start`=1.
- IDLE behaviour:
  - Non-start beats are discarded; no output changes.
  - On a start beat: `sh[0]`<=`din`, `slot`<=1, go to RUN.
- RUN, non-start beat with `slot`<N-1: `sh[slot]`<=`din`, `slot`<=`slot`+1.
- RUN, non-start beat with `slot`=N-1 (frame completion):
  - `w`<={`din`, `sh[N-2:0]`}.
  - `frame_valid`<=1, `slot`<=0, go to IDLE.
- RUN, start beat (any slot ≥ 1), resync:
  - Abandon the partial frame.
  - `sh[0]`<=`din`, `slot`<=1, stay in RUN.
  - `sync_err`<=1 (if enabled); `w` is unchanged.
- Consecutive frames: the beat after a completion must be a start beat. Otherwise it is discarded in IDLE.
- Gaps: `din_valid` low for any number of cycles holds all state. Frames may be stretched arbitrarily.
- Stale `sh` bits from an abandoned frame are always overwritten before completion, so no masking is needed.

## Timing
- Reset values: `w`=0, `sh`=0, `slot`=0, `frame_valid`=0, `sync_err`=0, state=IDLE.
- Reset has priority over every beat, including a completing beat. That beat is lost and no `frame_valid` is issued.
- Reset mid-frame discards the partial frame silently; `sync_err` is not asserted.
- Latency: `w` and `frame_valid` update at the same edge that samples slot N-1. Both are visible the following cycle. The minimum frame is N consecutive beats, giving a throughput of 1 frame per N cycles.
- `frame_valid` and `sync_err` are registered pulses, high for exactly one cycle, and never high in the same cycle.
- `slot` is registered and equals 0 whenever the state is IDLE.
- All outputs are driven from flops; there is no combinational path from input to output.

## Configuration
- Macro: `TDM_DEMUX_SYNC_ERR_EN`.
- Defined: the `sync_err` pulse is generated on each resync, as described above.
- Undefined: the `sync_err` port remains but is tied to 0 and the resync logic for it is omitted. Resync behaviour of `sh`/`slot`/state is identical either way.

## Test plan
- Reset, then N=4, beats with `din`=1,0,1,1 (first with `frame_start`) -> `w`=4'b1101, `frame_valid` high for 1 cycle, `slot` back to 0.
- Same frame with `din_valid` low for 3 cycles between slots 1 and 2 -> same `w`=4'b1101, exactly one `frame_valid`.
- Beats 1,1 without `frame_start` in IDLE, then a start frame 0,0,1,0 -> `w`=4'b0100; the earlier beats are ignored.
- Start frame 1,1 then a start beat with `din`=0 followed by 1,1,0 -> `sync_err` pulse at the resync edge (0 when the macro is undefined), `w`=4'b0110.
- Two back-to-back frames 1,0,0,0 then 0,1,1,1 (with `frame_start` on each slot 0) -> `w`=4'b0001 then 4'b1110, with `frame_valid` pulses 4 cycles apart.
- Assert `reset` on the slot-3 beat of a frame -> `w` stays 0, no `frame_valid`, state IDLE, `slot`=0.

Source files
------------

// File: rtl/tdm_demux_1bit.sv
// ============================================================================
// Module      : tdm_demux_1bit
// Description : Reassembles a 1-bit TDM serial stream into N-bit parallel
//               frames and publishes each completed frame atomically.
//               Optional macro TDM_DEMUX_SYNC_ERR_EN enables the sync_err
//               pulse on resync.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tdm_demux_1bit #(
  parameter int N = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 din,
  input  logic                 din_valid,
  input  logic                 frame_start,
  output logic [N-1:0]         w,
  output logic [$clog2(N)-1:0] slot,
  output logic                 frame_valid,
  output logic                 sync_err
);

  localparam int SW = $clog2(N);
  localparam logic [SW-1:0] c_last_slot = SW'(N - 1);

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  state_t        r_state;
  logic [N-1:0]  r_sh;
  logic [N-1:0]  r_w;
  logic [SW-1:0] r_slot;
  logic          r_frame_valid;
`ifdef TDM_DEMUX_SYNC_ERR_EN
  logic          r_sync_err;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= S_IDLE;
      r_sh          <= '0;
      r_w           <= '0;
      r_slot        <= '0;
      r_frame_valid <= 1'b0;
`ifdef TDM_DEMUX_SYNC_ERR_EN
      r_sync_err    <= 1'b0;
`endif
    end else begin
      r_frame_valid <= 1'b0;
`ifdef TDM_DEMUX_SYNC_ERR_EN
      r_sync_err    <= 1'b0;
`endif
      if (din_valid) begin
        if (frame_start) begin
          // A start beat always restarts the frame; in RUN it abandons the partial one.
`ifdef TDM_DEMUX_SYNC_ERR_EN
          if (r_state == S_RUN) begin
            r_sync_err <= 1'b1;
          end
`endif
          r_sh[0] <= din;
          r_slot  <= SW'(1);
          r_state <= S_RUN;
        end else if (r_state == S_RUN) begin
          if (r_slot == c_last_slot) begin
            r_w           <= {din, r_sh[N-2:0]};
            r_frame_valid <= 1'b1;
            r_slot        <= '0;
            r_state       <= S_IDLE;
          end else begin
            r_sh[r_slot] <= din;
            r_slot       <= r_slot + SW'(1);
          end
        end
      end
    end
  end

  assign w           = r_w;
  assign slot        = r_slot;
  assign frame_valid = r_frame_valid;
`ifdef TDM_DEMUX_SYNC_ERR_EN
  assign sync_err    = r_sync_err;
`else
  assign sync_err    = 1'b0;
`endif

endmodule

`default_nettype wire
